// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the RV32I-subset control path.
// Holds the FSM state enum, opcode constants, ALU / immediate / result
// encodings and mux-select constants. The single-cycle control imports the
// same package so both datapaths agree on every encoding.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_UPPER     = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // alu_control
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // imm_type
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // result_source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;
    localparam logic [1:0] RES_UPPER  = 2'b11;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Base operand of the upper-immediate adder
    localparam logic [1:0] BASE_OLDPC = 2'b00;  // AUIPC
    localparam logic [1:0] BASE_ZERO  = 2'b01;  // LUI

    // Immediate format is purely a function of the opcode, independent of state.
    function automatic logic [2:0] imm_type_for(input logic [6:0] op);
        logic [2:0] t;
        t = IMM_I;
        case (op)
            OP_STORE:         t = IMM_S;
            OP_BRANCH:        t = IMM_B;
            OP_JAL:           t = IMM_J;
            OP_LUI, OP_AUIPC: t = IMM_U;
            default:          t = IMM_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Unified-memory handshake between the controller (master) and memory (slave).
//   mem_req   : request, held stable until the mem_ready cycle
//   mem_write : write strobe accompanying mem_req
//   addr_src  : address select, 0 = PC, 1 = ALUOut
//   mem_ready : completion, only meaningful while mem_req = 1
interface multicycle_control_if;
    logic mem_req;
    logic mem_write;
    logic addr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output addr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  addr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU operation decoder.
//   op_code, func3, func7_5 : instruction fields (func7_5 = func7[5])
//   alu_control             : ALU operation encoding
//   bad_func                : func3 has no supported operation
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] op_code,
    input  logic [2:0] func3,
    input  logic       func7_5,
    output logic [2:0] alu_control,
    output logic       bad_func
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_func    = 1'b0;
        case (func3)
            // func7[5] selects SUB only for register-register ops; in ADDI
            // that bit is part of the immediate.
            3'b000:  alu_control = (op_code == OP_RTYPE && func7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b100:  alu_control = ALU_XOR;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: bad_func    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM.
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_bus          : memory handshake (mem_req, mem_write, addr_src, mem_ready)
//   op_code/func3/func7, zero : latched instruction fields, ALU zero flag
//   ir_write, pc_write, reg_write : architectural update strobes
//   alu_src_a/b, alu_control, imm_type, result_source, addr_base_src : datapath selects
//   illegal, instr_retired, state : status / debug
// ILLEGAL_HALT = 1 parks in ILLEGAL until reset; 0 flags one cycle then refetches.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        mem_bus,
    input  logic [6:0]                  op_code,
    input  logic [2:0]                  func3,
    input  logic [6:0]                  func7,
    input  logic                        zero,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic                        reg_write,
    output logic [1:0]                  alu_src_a,
    output logic [1:0]                  alu_src_b,
    output logic [2:0]                  alu_control,
    output logic [2:0]                  imm_type,
    output logic [1:0]                  result_source,
    output logic [1:0]                  addr_base_src,
    output logic                        illegal,
    output logic                        instr_retired,
    output logic [3:0]                  state
);

    state_t     state_reg, state_next;
    logic [2:0] dec_alu_control;
    logic       dec_bad_func;

    logic       mem_req_c, mem_write_c, addr_src_c;
    logic       ir_write_c, pc_write_c, reg_write_c, illegal_c, retired_c;

    alu_decoder u_alu_decoder (
        .op_code     (op_code),
        .func3       (func3),
        .func7_5     (func7[5]),
        .alu_control (dec_alu_control),
        .bad_func    (dec_bad_func)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_FETCH;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        mem_req_c     = 1'b0;
        mem_write_c   = 1'b0;
        addr_src_c    = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        illegal_c     = 1'b0;
        retired_c     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_control   = ALU_ADD;
        result_source = RES_ALUOUT;
        addr_base_src = BASE_OLDPC;

        case (state_reg)
            ST_FETCH: begin
                // PC + 4 computed alongside the instruction read.
                mem_req_c = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch/jump target oldPC + imm is parked in ALUOut here.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op_code)
                    OP_LOAD, OP_STORE: state_next = ST_MEM_ADDR;
                    OP_RTYPE:          state_next = dec_bad_func ? ST_ILLEGAL : ST_EXEC_R;
                    OP_ITYPE:          state_next = dec_bad_func ? ST_ILLEGAL : ST_EXEC_I;
                    OP_BRANCH:         state_next = (func3 == 3'b000) ? ST_BRANCH : ST_ILLEGAL;
                    OP_JAL:            state_next = ST_JAL;
                    OP_LUI, OP_AUIPC:  state_next = ST_UPPER;
                    default:           state_next = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (op_code == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_req_c  = 1'b1;
                addr_src_c = 1'b1;
                if (mem_bus.mem_ready) state_next = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write_c   = 1'b1;
                result_source = RES_MEM;
                retired_c     = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                addr_src_c  = 1'b1;
                if (mem_bus.mem_ready) begin
                    retired_c  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC_R, ST_EXEC_I: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = (state_reg == ST_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                alu_control = dec_alu_control;
                state_next  = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write_c = 1'b1;
                retired_c   = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_BRANCH: begin
                // PC takes the target held in ALUOut only when rs1 == rs2.
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                pc_write_c  = zero;
                retired_c   = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_JAL: begin
                pc_write_c    = 1'b1;
                reg_write_c   = 1'b1;
                result_source = RES_PC4;
                retired_c     = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_UPPER: begin
                reg_write_c   = 1'b1;
                result_source = RES_UPPER;
                addr_base_src = (op_code == OP_LUI) ? BASE_ZERO : BASE_OLDPC;
                retired_c     = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_ILLEGAL: begin
                illegal_c = 1'b1;
                if (ILLEGAL_HALT == 1'b0) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    assign imm_type = imm_type_for(op_code);
    assign state    = state_reg;

    // Strobes are masked by rst_n so an outstanding request drops the moment
    // reset asserts, without waiting for a clock edge.
    assign mem_bus.mem_req   = mem_req_c   & rst_n;
    assign mem_bus.mem_write = mem_write_c & rst_n;
    assign mem_bus.addr_src  = addr_src_c;
    assign ir_write          = ir_write_c  & rst_n;
    assign pc_write          = pc_write_c  & rst_n;
    assign reg_write         = reg_write_c & rst_n;
    assign illegal           = illegal_c   & rst_n;
    assign instr_retired     = retired_c   & rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_code;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       mem_ready_tb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus_a ();
    multicycle_control_if bus_b ();
    assign bus_a.mem_ready = mem_ready_tb;
    assign bus_b.mem_ready = mem_ready_tb;

    logic       a_ir_write, a_pc_write, a_reg_write, a_illegal, a_instr_retired;
    logic [1:0] a_alu_src_a, a_alu_src_b, a_result_source, a_addr_base_src;
    logic [2:0] a_alu_control, a_imm_type;
    logic [3:0] a_state;
    logic       b_ir_write, b_pc_write, b_reg_write, b_illegal, b_instr_retired;
    logic [1:0] b_alu_src_a, b_alu_src_b, b_result_source, b_addr_base_src;
    logic [2:0] b_alu_control, b_imm_type;
    logic [3:0] b_state;

    multicycle_control #(.ILLEGAL_HALT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_bus(bus_a.master),
        .op_code(op_code), .func3(func3), .func7(func7), .zero(zero),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_control(a_alu_control),
        .imm_type(a_imm_type), .result_source(a_result_source), .addr_base_src(a_addr_base_src),
        .illegal(a_illegal), .instr_retired(a_instr_retired), .state(a_state)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) u_dut_nohalt (
        .clk(clk), .rst_n(rst_n), .mem_bus(bus_b.master),
        .op_code(op_code), .func3(func3), .func7(func7), .zero(zero),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_control(b_alu_control),
        .imm_type(b_imm_type), .result_source(b_result_source), .addr_base_src(b_addr_base_src),
        .illegal(b_illegal), .instr_retired(b_instr_retired), .state(b_state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        op_code = op;
        func3   = f3;
        func7   = f7;
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_ready_tb = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ready_tb = 1'b0; zero = 1'b0;
        op_code = 7'd0; func3 = 3'd0; func7 = 7'd0;
        repeat (3) tick();
        n_cmp++; if (a_state !== 4'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", a_state); end
        n_cmp++; if (bus_a.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", bus_a.mem_req); end
        n_cmp++; if ({a_ir_write, a_pc_write, a_reg_write, a_illegal, a_instr_retired} !== 5'b0) begin
            n_err++; $display("FAIL rst_strobes got %b want 00000", {a_ir_write, a_pc_write, a_reg_write, a_illegal, a_instr_retired}); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if ({bus_a.mem_req, bus_a.addr_src, a_alu_src_b} !== 4'b1010) begin
            n_err++; $display("FAIL fetch_req got %b want 1010", {bus_a.mem_req, bus_a.addr_src, a_alu_src_b}); end
        n_cmp++; if (a_ir_write !== 1'b0) begin n_err++; $display("FAIL fetch_wait_irw got %b want 0", a_ir_write); end
        tick();
        n_cmp++; if (a_state !== 4'd0 || bus_a.mem_req !== 1'b1) begin
            n_err++; $display("FAIL fetch_wait_hold got state %0d req %b want 0 1", a_state, bus_a.mem_req); end
        mem_ready_tb = 1'b1;
        #1;
    endtask

    task automatic test_lw;
        int ret;
        load_instr(7'b0000011, 3'b010, 7'd0);
        ret = a_instr_retired;
        n_cmp++; if ({a_ir_write, a_pc_write, a_alu_control} !== 5'b11000) begin
            n_err++; $display("FAIL lw_c1 got %b want 11000", {a_ir_write, a_pc_write, a_alu_control}); end
        tick(); ret += a_instr_retired;
        n_cmp++; if ({a_state, a_alu_src_a, a_alu_src_b, bus_a.mem_req} !== {4'd1, 2'b01, 2'b01, 1'b0}) begin
            n_err++; $display("FAIL lw_c2 got %0d %b %b %b want 1 01 01 0", a_state, a_alu_src_a, a_alu_src_b, bus_a.mem_req); end
        tick(); ret += a_instr_retired;
        n_cmp++; if ({a_state, a_alu_src_a, a_alu_src_b} !== {4'd2, 2'b10, 2'b01}) begin
            n_err++; $display("FAIL lw_c3 got %0d %b %b want 2 10 01", a_state, a_alu_src_a, a_alu_src_b); end
        tick(); ret += a_instr_retired;
        n_cmp++; if ({a_state, bus_a.mem_req, bus_a.addr_src, bus_a.mem_write} !== {4'd3, 3'b110}) begin
            n_err++; $display("FAIL lw_c4 got %0d %b%b%b want 3 110", a_state, bus_a.mem_req, bus_a.addr_src, bus_a.mem_write); end
        tick(); ret += a_instr_retired;
        n_cmp++; if ({a_state, a_reg_write, a_result_source, a_instr_retired} !== {4'd4, 1'b1, 2'b01, 1'b1}) begin
            n_err++; $display("FAIL lw_c5 got %0d %b %b %b want 4 1 01 1", a_state, a_reg_write, a_result_source, a_instr_retired); end
        n_cmp++; if (ret !== 1) begin n_err++; $display("FAIL lw_retire_count got %0d want 1", ret); end
        tick();
        n_cmp++; if (a_state !== 4'd0) begin n_err++; $display("FAIL lw_back_fetch got %0d want 0", a_state); end
    endtask

    task automatic test_sw_wait;
        load_instr(7'b0100011, 3'b010, 7'd0);
        tick();
        n_cmp++; if (a_imm_type !== 3'b001) begin n_err++; $display("FAIL sw_imm got %b want 001", a_imm_type); end
        mem_ready_tb = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ready_tb = 1'b1; #1; end
            n_cmp++; if ({a_state, bus_a.mem_req, bus_a.mem_write, bus_a.addr_src} !== {4'd5, 3'b111}) begin
                n_err++; $display("FAIL sw_hold%0d got %0d %b%b%b want 5 111", i, a_state, bus_a.mem_req, bus_a.mem_write, bus_a.addr_src); end
            n_cmp++; if (a_instr_retired !== (i == 3)) begin
                n_err++; $display("FAIL sw_retire%0d got %b want %b", i, a_instr_retired, (i == 3)); end
            if (i < 3) tick();
        end
        tick();
        n_cmp++; if (a_state !== 4'd0 || a_instr_retired !== 1'b0) begin
            n_err++; $display("FAIL sw_after got %0d %b want 0 0", a_state, a_instr_retired); end
    endtask

    task automatic test_beq(input logic zv);
        zero = zv;
        load_instr(7'b1100011, 3'b000, 7'd0);
        tick();
        n_cmp++; if (a_imm_type !== 3'b010) begin n_err++; $display("FAIL beq_imm got %b want 010", a_imm_type); end
        tick();
        n_cmp++; if ({a_state, a_pc_write, a_alu_control, a_alu_src_a, a_alu_src_b} !== {4'd9, zv, 3'b001, 2'b10, 2'b00}) begin
            n_err++; $display("FAIL beq_z%0d got %0d %b %b %b %b want 9 %b 001 10 00", zv, a_state, a_pc_write, a_alu_control, a_alu_src_a, a_alu_src_b, zv); end
        n_cmp++; if ({a_instr_retired, a_reg_write} !== 2'b10) begin
            n_err++; $display("FAIL beq_retire_z%0d got %b want 10", zv, {a_instr_retired, a_reg_write}); end
        tick();
        zero = 1'b0;
    endtask

    task automatic test_alu_ops;
        // SUB
        load_instr(7'b0110011, 3'b000, 7'b0100000);
        tick(); tick();
        n_cmp++; if ({a_state, a_alu_control, a_alu_src_a, a_alu_src_b} !== {4'd6, 3'b001, 2'b10, 2'b00}) begin
            n_err++; $display("FAIL sub_exec got %0d %b %b %b want 6 001 10 00", a_state, a_alu_control, a_alu_src_a, a_alu_src_b); end
        tick();
        n_cmp++; if ({a_state, a_reg_write, a_result_source, a_instr_retired} !== {4'd8, 1'b1, 2'b00, 1'b1}) begin
            n_err++; $display("FAIL sub_wb got %0d %b %b %b want 8 1 00 1", a_state, a_reg_write, a_result_source, a_instr_retired); end
        tick();
        // SLTI
        load_instr(7'b0010011, 3'b010, 7'd0);
        tick(); tick();
        n_cmp++; if ({a_state, a_alu_control, a_alu_src_b} !== {4'd7, 3'b101, 2'b01}) begin
            n_err++; $display("FAIL slti_exec got %0d %b %b want 7 101 01", a_state, a_alu_control, a_alu_src_b); end
        tick(); tick();
        // ADDI with imm bit 10 set must stay ADD
        load_instr(7'b0010011, 3'b000, 7'b0100000);
        tick(); tick();
        n_cmp++; if ({a_state, a_alu_control} !== {4'd7, 3'b000}) begin
            n_err++; $display("FAIL addi_f7 got %0d %b want 7 000", a_state, a_alu_control); end
        tick(); tick();
    endtask

    task automatic test_jal_upper;
        load_instr(7'b1101111, 3'b000, 7'd0);
        tick(); tick();
        n_cmp++; if ({a_state, a_pc_write, a_reg_write, a_result_source, a_imm_type, a_instr_retired} !== {4'd10, 2'b11, 2'b10, 3'b011, 1'b1}) begin
            n_err++; $display("FAIL jal got %0d %b%b %b %b %b want 10 11 10 011 1", a_state, a_pc_write, a_reg_write, a_result_source, a_imm_type, a_instr_retired); end
        tick();
        load_instr(7'b0110111, 3'b000, 7'd0);
        tick(); tick();
        n_cmp++; if ({a_state, a_reg_write, a_result_source, a_imm_type, a_addr_base_src, a_pc_write} !== {4'd11, 1'b1, 2'b11, 3'b100, 2'b01, 1'b0}) begin
            n_err++; $display("FAIL lui got %0d %b %b %b %b %b want 11 1 11 100 01 0", a_state, a_reg_write, a_result_source, a_imm_type, a_addr_base_src, a_pc_write); end
        tick();
        load_instr(7'b0010111, 3'b000, 7'd0);
        tick(); tick();
        n_cmp++; if ({a_state, a_imm_type, a_addr_base_src, a_instr_retired} !== {4'd11, 3'b100, 2'b00, 1'b1}) begin
            n_err++; $display("FAIL auipc got %0d %b %b %b want 11 100 00 1", a_state, a_imm_type, a_addr_base_src, a_instr_retired); end
        tick();
    endtask

    task automatic test_illegal;
        load_instr(7'b1111111, 3'b000, 7'd0);
        tick(); tick();
        n_cmp++; if ({a_state, a_illegal, bus_a.mem_req, bus_a.mem_write, a_reg_write, a_pc_write, a_ir_write} !== {4'd12, 6'b100000}) begin
            n_err++; $display("FAIL ill_a got %0d %b %b%b%b%b%b want 12 1 00000", a_state, a_illegal, bus_a.mem_req, bus_a.mem_write, a_reg_write, a_pc_write, a_ir_write); end
        n_cmp++; if ({b_state, b_illegal} !== {4'd12, 1'b1}) begin
            n_err++; $display("FAIL ill_b got %0d %b want 12 1", b_state, b_illegal); end
        tick();
        n_cmp++; if ({b_state, b_illegal} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL ill_nohalt_ret got %0d %b want 0 0", b_state, b_illegal); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({a_state, a_illegal} !== {4'd12, 1'b1}) begin
                n_err++; $display("FAIL ill_halt%0d got %0d %b want 12 1", i, a_state, a_illegal); end
            tick();
        end
        do_reset();
        load_instr(7'b0110011, 3'b001, 7'd0);
        tick(); tick();
        n_cmp++; if (a_state !== 4'd12) begin n_err++; $display("FAIL ill_rfunc3 got %0d want 12", a_state); end
        do_reset();
        load_instr(7'b1100011, 3'b001, 7'd0);
        tick(); tick();
        n_cmp++; if (a_state !== 4'd12) begin n_err++; $display("FAIL ill_bne got %0d want 12", a_state); end
        do_reset();
    endtask

    task automatic test_reset_mid;
        load_instr(7'b0000011, 3'b010, 7'd0);
        tick();
        mem_ready_tb = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({a_state, bus_a.mem_req, bus_a.addr_src} !== {4'd3, 2'b11}) begin
            n_err++; $display("FAIL rmid_wait got %0d %b%b want 3 11", a_state, bus_a.mem_req, bus_a.addr_src); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_state, bus_a.mem_req, bus_a.mem_write, a_reg_write} !== {4'd0, 3'b000}) begin
            n_err++; $display("FAIL rmid_async got %0d %b%b%b want 0 000", a_state, bus_a.mem_req, bus_a.mem_write, a_reg_write); end
        #2;
        rst_n = 1'b1;
        #1;
        tick();
        n_cmp++; if ({a_state, bus_a.mem_req, bus_a.addr_src} !== {4'd0, 2'b10}) begin
            n_err++; $display("FAIL rmid_after got %0d %b%b want 0 10", a_state, bus_a.mem_req, bus_a.addr_src); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_alu_ops();
        test_jal_upper();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ILLEGAL_HALT, default 1: 1 = park in ILLEGAL until reset; 0 = flag illegal for one cycle, then return to FETCH.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports op_code in 7, func3 in 3, func7 in 7: fields of the latched instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  unified memory completion.
REQ-007 SHALL have ports mem_req out 1, mem_write out 1, addr_src out 1: memory request, write strobe, and address select (0 = PC, 1 = ALUOut).
REQ-008 SHALL have ports ir_write out 1, pc_write out 1, reg_write out 1: architectural register update strobes.
REQ-009 SHALL have ports alu_src_a out 2 (00 PC, 01 oldPC, 10 rs1) and alu_src_b out 2 (00 rs2, 01 imm, 10 const 4).
REQ-010 SHALL have ports alu_control out 3, imm_type out 3, result_source out 2, addr_base_src out 2.
REQ-011 SHALL have ports illegal out 1, instr_retired out 1 (one-cycle retire pulse), and state out 4 (debug).

Function
REQ-012 Encodings SHALL be as follows.
- alu_control: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
- imm_type: 000 I, 001 S, 010 B, 011 J, 100 U.
- result_source: 00 ALUOut, 01 memory data, 10 PC+4, 11 upper-imm adder.
REQ-013 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, UPPER, ILLEGAL.
REQ-014 FETCH SHALL assert mem_req with addr_src=0, alu_src_a=00, alu_src_b=10, ADD.
- ir_write and pc_write assert only in the cycle mem_ready=1; that cycle transitions to DECODE.
REQ-015 Memory handshake rules:
- mem_req, mem_write and addr_src SHALL remain stable from assertion until the mem_ready cycle.
- mem_ready SHALL be ignored while mem_req=0.
REQ-016 DECODE SHALL use alu_src_a=01, alu_src_b=01, ADD (target into ALUOut), then branch on op_code:
- 0000011 and 0100011 -> MEM_ADDR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 and 0010111 -> UPPER
- anything else -> ILLEGAL
REQ-017 MEM_ADDR SHALL use alu_src_a=10, alu_src_b=01, ADD, then go to MEM_READ (load) or MEM_WRITE (store).
REQ-018 MEM_READ SHALL assert mem_req with addr_src=1 and wait for mem_ready, then go to MEM_WB; MEM_WB SHALL assert reg_write with result_source=01.
REQ-019 MEM_WRITE SHALL assert mem_req and mem_write with addr_src=1; on mem_ready it retires and returns to FETCH.
REQ-020 EXEC_R/EXEC_I SHALL use alu_src_a=10 and alu_src_b=00/01 respectively, with alu_control taken from func3/func7, then go to ALU_WB.
- ALU_WB asserts reg_write with result_source=00.
REQ-021 alu_control decoding from func3/func7:
- 000 ADD; SUB only when op_code=0110011 and func7[5]=1.
- 010 SLT, 100 XOR, 110 OR, 111 AND.
- Any other func3 SHALL go to ILLEGAL.
REQ-022 BRANCH SHALL apply only to func3=000 (BEQ).
- alu_src_a=10, alu_src_b=00, SUB; pc_write=zero; result_source=00.
- Any other func3 SHALL go to ILLEGAL.
REQ-023 JAL SHALL assert pc_write from ALUOut and reg_write with result_source=10 in the same cycle.
REQ-024 UPPER SHALL assert reg_write, result_source=11, imm_type=100, with addr_base_src=01 for LUI and 00 for AUIPC.
REQ-025 imm_type SHALL follow op_code in every state: I for 0000011/0010011, S for 0100011, B for 1100011, J for 1101111, U for LUI/AUIPC.
REQ-026 Every terminal state (MEM_WB, MEM_WRITE on mem_ready, ALU_WB, BRANCH, JAL, UPPER) SHALL pulse instr_retired for exactly one cycle and return to FETCH.
REQ-027 Latency with mem_ready tied high SHALL be: load 5 cycles; store, R-type and I-type 4; branch, JAL and upper 3. Each wait cycle adds one.
REQ-028 In ILLEGAL, illegal=1 and all write strobes and mem_req SHALL be 0.
REQ-029 Strobes not listed for a state SHALL be 0; mux selects not listed are don't-care but SHALL be driven to 0.

Reset
REQ-030 rst_n=0 SHALL force state=FETCH asynchronously.
- All strobes, illegal and instr_retired read 0 during reset.
- Mid-operation reset SHALL abandon any outstanding memory request without a write strobe.
REQ-031 The first rising clk edge after rst_n deasserts SHALL begin a FETCH request.

Structure
REQ-032 A shared package SHALL hold the state enum, opcode constants, and the alu_control, imm_type and result_source encodings; the existing single-cycle control SHALL import the same encodings.
REQ-033 alu_decoder SHALL be a separate combinational sub-module (func3, func7[5], op_code -> alu_control, bad_func).

Verification
REQ-034 LW, mem_ready high: retires in 5 cycles; result_source=01 with reg_write=1 in cycle 5; instr_retired=1 once.
REQ-035 SW with mem_ready held low 3 cycles in MEM_WRITE: mem_req, mem_write and addr_src=1 stay stable for 4 cycles; retires the cycle after.
REQ-036 BEQ with zero=1 gives pc_write=1 in cycle 3; with zero=0, pc_write=0 in cycle 3; both retire.
REQ-037 R-type SUB (func7=0100000, func3=000) gives alu_control=001. SLTI (0010011, func3=010) gives 101 with alu_src_b=01.
REQ-038 op_code=1111111 leads to ILLEGAL with illegal=1; it stays there for 10 cycles with ILLEGAL_HALT=1 and returns to FETCH after 1 cycle with 0.
REQ-039 rst_n pulsed low during MEM_READ wait: mem_req drops with no clock edge; after release, state=FETCH.
